chebyshev_term_gen: RTL and testbench

//  Sequential Chebyshev basis generator. Accepts one fixed-point argument x and streams
//  T_0(x)..T_DEGREE(x) with a valid/ready handshake, one term per accepted beat.

---
 rtl/chebyshev_term_gen_pkg.sv | 9 +
 rtl/chebyshev_term_gen_recur_step.sv | 26 ++
 rtl/chebyshev_term_gen.sv | 72 +++++++
 tb/tb_chebyshev_term_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/chebyshev_term_gen_pkg.sv
// chebyshev_term_gen_pkg: FSM encodings and sizing helpers shared by the Chebyshev stream blocks
package chebyshev_term_gen_pkg;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    function automatic int idx_w(input int degree);
        return (degree < 1) ? 1 : $clog2(degree + 1);
    endfunction
endpackage

// File: rtl/chebyshev_term_gen_recur_step.sv
// chebyshev_term_gen_recur_step: combinational rounded, saturated 2*x*t_cur - t_prev
module chebyshev_term_gen_recur_step #(
    parameter int WL_X = 16,
    parameter int FRAC = 14
) (
    input  logic [WL_X-1:0] x,
    input  logic [WL_X-1:0] t_cur,
    input  logic [WL_X-1:0] t_prev,
    output logic [WL_X-1:0] t_next
);
    localparam int PW = 2 * WL_X + 1;
    localparam logic signed [PW-1:0] RND  = PW'(1) <<< (FRAC - 2);
    localparam logic signed [PW-1:0] MAXV = (PW'(1) <<< (WL_X - 1)) - PW'(1);
    localparam logic signed [PW-1:0] MINV = -(PW'(1) <<< (WL_X - 1));

    logic signed [PW-1:0] xe, te, pe, p, d, r;

    assign xe = PW'($signed(x));
    assign te = PW'($signed(t_cur));
    assign pe = PW'($signed(t_prev));
    assign p  = xe * te;
    // shifting by FRAC-1 instead of FRAC folds in the factor of two
    assign d  = (p + RND) >>> (FRAC - 1);
    assign r  = d - pe;
    assign t_next = (r > MAXV) ? MAXV[WL_X-1:0] : (r < MINV) ? MINV[WL_X-1:0] : r[WL_X-1:0];
endmodule

// File: rtl/chebyshev_term_gen.sv
// chebyshev_term_gen: streams T_0(x)..T_DEGREE(x) via T_n+1 = 2x*T_n - T_n-1
// with a valid/ready handshake on both the argument and the term stream.
module chebyshev_term_gen
    import chebyshev_term_gen_pkg::*;
#(
    parameter int WL_X   = 16,
    parameter int FRAC   = 14,
    parameter int DEGREE = 7,
    localparam int IW    = idx_w(DEGREE)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WL_X-1:0] in_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WL_X-1:0] out_term,
    output logic [IW-1:0]   out_index,
    output logic            out_last
);
    localparam logic [WL_X-1:0] ONE  = WL_X'(1) << FRAC;
    localparam logic [IW-1:0]   LAST = IW'(DEGREE);

    logic [0:0]      state;
    logic [WL_X-1:0] x_reg, t_cur, t_prev, t_step, t_next;

    chebyshev_term_gen_recur_step #(.WL_X(WL_X), .FRAC(FRAC)) u_step (
        .x      (x_reg),
        .t_cur  (t_cur),
        .t_prev (t_prev),
        .t_next (t_step)
    );

    assign in_ready = resetn && (state == ST_IDLE);
    assign t_next   = (out_index == '0) ? x_reg : t_step;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            x_reg     <= '0;
            t_cur     <= '0;
            t_prev    <= '0;
            out_valid <= 1'b0;
            out_term  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (in_valid) begin
                x_reg     <= in_x;
                t_cur     <= ONE;
                t_prev    <= ONE;
                out_valid <= 1'b1;
                out_term  <= ONE;
                out_index <= '0;
                out_last  <= (DEGREE == 0);
                state     <= ST_EMIT;
            end
        end else if (out_ready) begin
            if (out_last) begin
                out_valid <= 1'b0;
                state     <= ST_IDLE;
            end else begin
                t_prev    <= t_cur;
                t_cur     <= t_next;
                out_term  <= t_next;
                out_index <= out_index + 1'b1;
                out_last  <= (out_index + 1'b1) == LAST;
            end
        end
    end
endmodule

// File: tb/tb_chebyshev_term_gen.sv
// tb_chebyshev_term_gen: table vectors, corner sequences and randomized runs against an integer model
module tb_chebyshev_term_gen;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [15:0] in_x = '0;
    logic        in_ready, out_valid, out_last;
    logic [15:0] out_term;
    logic [2:0]  out_index;

    logic        z_in_valid = 1'b0, z_out_ready = 1'b1;
    logic [15:0] z_in_x = '0;
    logic        z_in_ready, z_out_valid, z_out_last;
    logic [15:0] z_out_term;
    logic [0:0]  z_out_index;

    int n_cmp = 0, n_bad = 0;

    always #5 clock = ~clock;

    chebyshev_term_gen #(.WL_X(16), .FRAC(14), .DEGREE(4)) u_dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready),
        .out_term(out_term), .out_index(out_index), .out_last(out_last)
    );

    chebyshev_term_gen #(.WL_X(16), .FRAC(14), .DEGREE(0)) u_dut0 (
        .clock(clock), .resetn(resetn), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_x(z_in_x), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_term(z_out_term), .out_index(z_out_index), .out_last(z_out_last)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] t [5];
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // T_n in Q2.14 from the recurrence with exact floor rounding of 2*x*t + 0.5 lsb
    function automatic logic [15:0] ref_term(input logic [15:0] x, input int n);
        longint xv, tp, tc, nt;
        xv = longint'($signed(x));
        tp = 16384;
        tc = xv;
        if (n == 0) return 16'h4000;
        for (int k = 2; k <= n; k++) begin
            nt = fdiv(2 * xv * tc + 8192, 16384) - tp;
            if (nt > 32767) nt = 32767;
            if (nt < -32768) nt = -32768;
            tp = tc;
            tc = nt;
        end
        return tc[15:0];
    endfunction

    task automatic check_beat(input string nm, input logic [15:0] et, input int n);
        check({nm, " valid"}, 32'(out_valid), 32'd1);
        check({nm, " term"}, 32'(out_term), 32'(et));
        check({nm, " index"}, 32'(out_index), 32'(n));
        check({nm, " last"}, 32'(out_last), 32'(n == 4));
        check({nm, " in_ready"}, 32'(in_ready), 32'd0);
    endtask

    // offer x at a negedge, then walk every term, stalling stall[n] cycles at term n
    task automatic run_seq(input string nm, input logic [15:0] x, input logic [15:0] et [5],
                           input int stall [5]);
        check({nm, " idle ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_x = x;
        @(posedge clock);
        #1 in_valid = 1'b0;
        in_x = 16'hDEAD;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            check_beat(nm, et[n], n);
            if (stall[n] > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall[n]; s++) begin
                    @(negedge clock);
                    check_beat({nm, " hold"}, et[n], n);
                end
                out_ready = 1'b1;
            end
        end
        @(negedge clock);
        check({nm, " end valid"}, 32'(out_valid), 32'd0);
        check({nm, " end ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t tbl [4];
        logic [15:0] et [5];
        int nost [5] = '{0, 0, 0, 0, 0};
        int st2 [5] = '{0, 0, 3, 0, 0};
        int rs [5];
        logic [15:0] rx;

        tbl[0].x = 16'h2000; tbl[0].t = '{16'h4000, 16'h2000, 16'hE000, 16'hC000, 16'hE000};
        tbl[1].x = 16'h4000; tbl[1].t = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
        tbl[2].x = 16'hC000; tbl[2].t = '{16'h4000, 16'hC000, 16'h4000, 16'hC000, 16'h4000};
        tbl[3].x = 16'h6000; tbl[3].t = '{16'h4000, 16'h6000, 16'h7FFF, 16'h7FFF, 16'h7FFF};

        #12;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_term", 32'(out_term), 32'd0);
        check("rst out_index", 32'(out_index), 32'd0);
        check("rst out_last", 32'(out_last), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 4; i++) run_seq($sformatf("tbl%0d", i), tbl[i].x, tbl[i].t, nost);

        run_seq("stall", tbl[0].x, tbl[0].t, st2);
        run_seq("b2b_a", tbl[2].x, tbl[2].t, nost);
        run_seq("b2b_b", tbl[0].x, tbl[0].t, nost);

        in_valid = 1'b1;
        in_x = 16'h2000;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check("pre-rst index", 32'(out_index), 32'd2);
        resetn = 1'b0;
        #1;
        check("async rst valid", 32'(out_valid), 32'd0);
        check("async rst ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("rst2 ready", 32'(in_ready), 32'd1);
        check("rst2 valid", 32'(out_valid), 32'd0);
        run_seq("after_rst", tbl[0].x, tbl[0].t, nost);

        for (int r = 0; r < 2; r++) begin
            z_in_valid = 1'b1;
            z_in_x = 16'h1234;
            @(posedge clock);
            #1 z_in_valid = 1'b0;
            @(negedge clock);
            check("d0 valid", 32'(z_out_valid), 32'd1);
            check("d0 term", 32'(z_out_term), 32'h4000);
            check("d0 index", 32'(z_out_index), 32'd0);
            check("d0 last", 32'(z_out_last), 32'd1);
            check("d0 busy", 32'(z_in_ready), 32'd0);
            @(negedge clock);
            check("d0 end valid", 32'(z_out_valid), 32'd0);
            check("d0 end ready", 32'(z_in_ready), 32'd1);
        end

        for (int r = 0; r < 24; r++) begin
            rx = 16'($urandom);
            if (r < 8) rx = 16'($urandom_range(0, 16'h8000)) - 16'h4000;
            for (int n = 0; n < 5; n++) begin
                et[n] = ref_term(rx, n);
                rs[n] = $urandom_range(0, 2);
            end
            run_seq($sformatf("rand%0d x=%h", r, rx), rx, et, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
